// File: rtl/alarm_timer.sv
// alarm_timer: 1 Hz / 0.5 Hz timebase, four programmable delays (seconds)
// and a seconds countdown that signals expiry with a one-cycle pulse.
module alarm_timer #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int DEF_ARM       = 6,
    parameter int DEF_DRIVER    = 8,
    parameter int DEF_PASSENGER = 15,
    parameter int DEF_ALARM_ON  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval_sel,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       one_hz_enable,
    output logic       half_hz_enable
);
    localparam int PW = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] LAST = PW'(CLK_FREQ - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [3:0]    param [4];
    logic [3:0]    loaded;
    logic          tick;

    assign tick   = prescaler == LAST;
    assign loaded = param[interval_sel];
    assign busy   = state == RUN;

    // start_timer takes priority over a same-edge tick or expiry; reads see the pre-write param
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state          <= IDLE;
            prescaler      <= '0;
            remaining      <= '0;
            expired        <= 1'b0;
            one_hz_enable  <= 1'b0;
            half_hz_enable <= 1'b0;
            param[0]       <= 4'(DEF_ARM);
            param[1]       <= 4'(DEF_DRIVER);
            param[2]       <= 4'(DEF_PASSENGER);
            param[3]       <= 4'(DEF_ALARM_ON);
        end else begin
            prescaler      <= (start_timer || tick) ? '0 : prescaler + 1'b1;
            one_hz_enable  <= tick;
            half_hz_enable <= half_hz_enable ^ tick;
            if (reprogram)
                param[time_param_sel] <= time_value;
            if (start_timer) begin
                remaining <= loaded;
                state     <= loaded != 4'd0 ? RUN : IDLE;
                expired   <= loaded == 4'd0;
            end else if (state == RUN && tick) begin
                remaining <= remaining - 1'b1;
                state     <= remaining == 4'd1 ? IDLE : RUN;
                expired   <= remaining == 4'd1;
            end else
                expired <= 1'b0;
        end
endmodule
